mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ADDR_BASE, default 1024, byte address mapped to memory word 0.
REQ-002 Parameter DEPTH, default 64, number of 32-bit data-memory words.
REQ-003 Parameter ACCESS_CYCLES, default 4 (legal range 2..15), number of cycles ready stays low for one memory access.
REQ-004 clk  input  1  single clock, all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 WB_en_in, mem_read_in, mem_write_in  input  1 each  control from the execute stage.
REQ-007 dst_in  input  4  destination register index.
REQ-008 ALU_res_in  input  32  ALU result, used as the byte address for memory operations.
REQ-009 val_Rm_in  input  32  store data.
REQ-010 ready  output  1  low means freeze all upstream pipeline registers and the PC.
REQ-011 WB_en_out, mem_read_out  output  1 each  registered control to write-back.
REQ-012 dst_out  output  4  registered destination.
REQ-013 ALU_res_out, mem_data_out  output  32 each  registered ALU result and load data.

Function
REQ-014 Word index = (ALU_res_in - ADDR_BASE) >> 2; address bits [1:0] are ignored.
REQ-015 Address in range means ADDR_BASE <= ALU_res_in < ADDR_BASE + 4*DEPTH; any other address is out of range.
REQ-016 A request is mem_read_in | mem_write_in; if both are high, the operation is a write.
REQ-017 FSM states: IDLE, BUSY, DONE; a 4-bit cycle counter runs only while in BUSY.
REQ-018 IDLE with no request: ready=1, and the output register loads all inputs on the next edge (1-cycle pass-through).
REQ-019 IDLE with a request: ready=0 combinationally; next state BUSY, counter=1.
REQ-020 BUSY: ready=0 and counter increments; when counter==ACCESS_CYCLES-1, next state is DONE.
REQ-021 Total ready-low cycles per access = ACCESS_CYCLES exactly, followed by 1 DONE cycle with ready=1.
REQ-022 DONE: ready=1; on the edge leaving DONE, a write commits to memory and a read result is captured into mem_data_out; next state is IDLE.
REQ-023 While ready=0, the output register loads a bubble: WB_en_out=0, mem_read_out=0, other outputs hold their values.
REQ-024 In DONE, the output register loads WB_en_in, mem_read_in, dst_in and ALU_res_in.
REQ-025 Out-of-range write: timing is unchanged and memory is not modified.
REQ-026 Out-of-range read: timing is unchanged and mem_data_out=0.
REQ-027 Non-load instructions: mem_data_out holds its previous value.
REQ-028 Inputs are held stable by upstream during ready=0; the block does not re-sample them mid-access.
REQ-029 Back-to-back requests: the request seen in IDLE on the cycle after DONE starts a new access with no extra idle cycle.

Reset
REQ-030 rst=1 forces state IDLE, counter=0, and all registered outputs to 0 on the next edge.
REQ-031 Reset during BUSY or DONE aborts the access, and no memory write occurs.
REQ-032 Memory contents are not cleared by reset.
REQ-033 ready is 1 during reset.

Verification
REQ-034 Pass-through: WB_en_in=1, dst_in=3, ALU_res_in=0x55, no request -> ready stays 1; next cycle WB_en_out=1, dst_out=3, ALU_res_out=0x55.
REQ-035 Store then load: write 0xDEADBEEF to address 1028, then read 1028 -> ready low 4 cycles for each access; after the read's DONE edge, mem_data_out=0xDEADBEEF, mem_read_out=1, WB_en_out=1 for exactly 1 cycle.
REQ-036 Bubble check: during the 4 ready-low cycles of a load to dst=5 -> WB_en_out=0 every cycle; WB_en_out=1 with dst_out=5 only once.
REQ-037 Out of range: write 0x1234 to address 512, then read 512 -> mem_data_out=0; a read of address 1024 still returns its prior contents.
REQ-038 Reset mid-access: write 0xA5A5A5A5 to 1032 and assert rst in the 2nd BUSY cycle -> outputs 0, state IDLE, ready=1; a later read of 1032 returns the old value.
REQ-039 Back-to-back: two loads issued in consecutive DONE/IDLE cycles -> ready pattern 0000 1 0000 1, and both load values are delivered in order.

Source files
------------

// File: rtl/mem_stage.sv
// Memory pipeline stage with a multi-cycle data-memory access.
// ready drops for ACCESS_CYCLES cycles per load/store, and the result is delivered on the DONE edge.
module mem_stage #(
  parameter int ADDR_BASE     = 1024,
  parameter int DEPTH         = 64,
  parameter int ACCESS_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_en_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [3:0]  dst_in,
  input  logic [31:0] ALU_res_in,
  input  logic [31:0] val_Rm_in,
  output logic        ready,
  output logic        WB_en_out,
  output logic        mem_read_out,
  output logic [3:0]  dst_out,
  output logic [31:0] ALU_res_out,
  output logic [31:0] mem_data_out
);

  localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] BASE  = 32'(ADDR_BASE);
  localparam logic [31:0] LIMIT = 32'(ADDR_BASE + 4 * DEPTH);
  localparam logic [3:0]  LAST  = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [3:0]        count;
  logic              req;
  logic              is_write;
  logic              is_read;
  logic              in_range;
  logic [31:0]       offset;
  logic [IDX_W-1:0]  idx;
  logic              unused_offset_bits;
  logic [31:0]       mem [DEPTH];

  assign req      = mem_read_in | mem_write_in;
  assign is_write = mem_write_in;
  assign is_read  = mem_read_in & ~mem_write_in;
  assign offset   = ALU_res_in - BASE;
  assign in_range = (ALU_res_in >= BASE) && (ALU_res_in < LIMIT);
  assign idx      = offset[IDX_W+1:2];
  assign unused_offset_bits = ^{offset[31:IDX_W+2], offset[1:0]};

  // State register and access cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= state_next;
      case (state)
        IDLE:    count <= req ? 4'd1 : 4'd0;
        BUSY:    count <= (count == LAST) ? 4'd0 : count + 4'd1;
        default: count <= 4'd0;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = req ? BUSY : IDLE;
      BUSY:    state_next = (count == LAST) ? DONE : BUSY;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stall output; forced high while reset is asserted
  always_comb begin
    ready = 1'b1;
    case (state)
      IDLE:    ready = rst | ~req;
      BUSY:    ready = rst;
      DONE:    ready = 1'b1;
      default: ready = 1'b1;
    endcase
  end

  // Data memory write port, committed only on the edge leaving DONE
  always_ff @(posedge clk) begin
    if (!rst && state == DONE && is_write && in_range) begin
      mem[idx] <= val_Rm_in;
    end
  end

  // Pipeline output register: bubble while stalled, load otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      WB_en_out    <= 1'b0;
      mem_read_out <= 1'b0;
      dst_out      <= 4'd0;
      ALU_res_out  <= 32'd0;
      mem_data_out <= 32'd0;
    end else if (!ready) begin
      WB_en_out    <= 1'b0;
      mem_read_out <= 1'b0;
    end else begin
      WB_en_out    <= WB_en_in;
      mem_read_out <= mem_read_in;
      dst_out      <= dst_in;
      ALU_res_out  <= ALU_res_in;
      if (state == DONE && is_read) begin
        mem_data_out <= in_range ? mem[idx] : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against an instruction-level reference model.
module tb_mem_stage;

  localparam int AB = 1024;
  localparam int D  = 64;
  localparam int AC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_en_in, mem_read_in, mem_write_in;
  logic [3:0]  dst_in;
  logic [31:0] ALU_res_in, val_Rm_in;
  logic        ready, WB_en_out, mem_read_out;
  logic [3:0]  dst_out;
  logic [31:0] ALU_res_out, mem_data_out;

  mem_stage #(.ADDR_BASE(AB), .DEPTH(D), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst(rst),
    .WB_en_in(WB_en_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .dst_in(dst_in), .ALU_res_in(ALU_res_in), .val_Rm_in(val_Rm_in),
    .ready(ready), .WB_en_out(WB_en_out), .mem_read_out(mem_read_out),
    .dst_out(dst_out), .ALU_res_out(ALU_res_out), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] ref_mem [D];
  logic        e_wb, e_mr;
  logic [3:0]  e_dst;
  logic [31:0] e_alu, e_md;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_wb"},   32'(WB_en_out),    32'(e_wb));
    check({tag, "_mr"},   32'(mem_read_out), 32'(e_mr));
    check({tag, "_dst"},  32'(dst_out),      32'(e_dst));
    check({tag, "_alu"},  ALU_res_out,       e_alu);
    check({tag, "_data"}, mem_data_out,      e_md);
  endtask

  // Reference: effect of one accepted instruction on memory and the stage outputs
  task automatic model_accept(input logic wb, input logic r, input logic w,
                              input logic [3:0] d, input logic [31:0] a, input logic [31:0] v);
    bit inr;
    int widx;
    inr  = (a >= 32'(AB)) && (a < 32'(AB + 4 * D));
    widx = inr ? int'((a - 32'(AB)) / 32'd4) : 0;
    if (w && inr) ref_mem[widx] = v;
    if (r && !w) e_md = inr ? ref_mem[widx] : 32'd0;
    e_wb  = wb;
    e_mr  = r;
    e_dst = d;
    e_alu = a;
  endtask

  task automatic run(input logic wb, input logic r, input logic w,
                     input logic [3:0] d, input logic [31:0] a, input logic [31:0] v);
    int lows;
    bit acc;
    @(negedge clk);
    WB_en_in = wb; mem_read_in = r; mem_write_in = w;
    dst_in = d; ALU_res_in = a; val_Rm_in = v;
    lows = 0;
    acc  = 1'b0;
    for (int c = 0; c < 40 && !acc; c++) begin
      #1;
      if (ready) begin
        acc = 1'b1;
      end else begin
        lows++;
        if (lows >= 2) begin
          check("bubble_wb",  32'(WB_en_out),    32'd0);
          check("bubble_mr",  32'(mem_read_out), 32'd0);
          check("hold_dst",   32'(dst_out),      32'(e_dst));
          check("hold_alu",   ALU_res_out,       e_alu);
        end
        @(negedge clk);
      end
    end
    check("ready_low_cycles", 32'(lows), (r | w) ? 32'(AC) : 32'd0);
    check("accepted", 32'(acc), 32'd1);
    if (acc) begin
      model_accept(wb, r, w, d, a, v);
      @(posedge clk);
      #1;
      check_outputs("out");
    end
  endtask

  task automatic reset_mid_write(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    WB_en_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b1;
    dst_in = 4'd0; ALU_res_in = a; val_Rm_in = v;
    #1 check("rm_ready_idle_req", 32'(ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rm_ready_in_rst", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    e_wb = 1'b0; e_mr = 1'b0; e_dst = 4'd0; e_alu = 32'd0; e_md = 32'd0;
    check_outputs("rm_after_rst");
    @(negedge clk);
    rst = 1'b0;
    WB_en_in = 1'b0; mem_write_in = 1'b0; ALU_res_in = 32'd0; val_Rm_in = 32'd0;
    #1 check("rm_ready_after", 32'(ready), 32'd1);
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] specials [6];
    specials[0] = 32'd512;
    specials[1] = 32'(AB - 4);
    specials[2] = 32'(AB + 4 * D);
    specials[3] = 32'(AB + 4 * D + 3);
    specials[4] = 32'hFFFF_FFFC;
    specials[5] = 32'(AB + 4 * D - 1);
    if ($urandom_range(0, 7) == 0) return specials[$urandom_range(0, 5)];
    return 32'(AB) + 32'($urandom_range(0, 4 * D - 1));
  endfunction

  initial begin
    logic [31:0] a;
    int kind;
    rst = 1'b1;
    WB_en_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    dst_in = 4'd0; ALU_res_in = 32'd0; val_Rm_in = 32'd0;
    e_wb = 1'b0; e_mr = 1'b0; e_dst = 4'd0; e_alu = 32'd0; e_md = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ready", 32'(ready), 32'd1);
    check_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < D; i++) run(1'b0, 1'b0, 1'b1, 4'd0, 32'(AB + 4 * i), $urandom);

    run(1'b1, 1'b0, 1'b0, 4'd3, 32'h55, 32'd0);
    run(1'b0, 1'b0, 1'b1, 4'd0, 32'd1028, 32'hDEAD_BEEF);
    run(1'b1, 1'b1, 1'b0, 4'd5, 32'd1028, 32'd0);
    check("store_load_data", mem_data_out, 32'hDEAD_BEEF);
    run(1'b1, 1'b0, 1'b0, 4'd7, 32'h99, 32'd0);
    run(1'b0, 1'b0, 1'b1, 4'd0, 32'd512, 32'h1234);
    run(1'b1, 1'b1, 1'b0, 4'd2, 32'd512, 32'd0);
    check("oor_read_zero", mem_data_out, 32'd0);
    run(1'b1, 1'b1, 1'b0, 4'd4, 32'd1024, 32'd0);

    reset_mid_write(32'd1032, 32'hA5A5_A5A5);
    run(1'b1, 1'b1, 1'b0, 4'd6, 32'd1032, 32'd0);
    run(1'b1, 1'b1, 1'b0, 4'd8, 32'd1036, 32'd0);
    run(1'b1, 1'b1, 1'b1, 4'd9, 32'd1040, 32'h0BAD_F00D);
    run(1'b1, 1'b1, 1'b0, 4'd10, 32'd1040, 32'd0);

    for (int n = 0; n < 200; n++) begin
      kind = int'($urandom_range(0, 4));
      a    = pick_addr();
      case (kind)
        0:       run(1'($urandom), 1'b0, 1'b0, 4'($urandom), $urandom, $urandom);
        1:       run(1'($urandom), 1'b1, 1'b0, 4'($urandom), a, $urandom);
        2:       run(1'b0, 1'b0, 1'b1, 4'($urandom), a, $urandom);
        3:       run(1'($urandom), 1'b1, 1'b1, 4'($urandom), a, $urandom);
        default: run(1'b1, 1'b1, 1'b0, 4'($urandom), a, $urandom);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
